// File: rtl/wbstage.sv
// rtl/wbstage.sv - LEGv8 write-back stage: result select, register file with bypassed reads, NZCV and retire count
module wbstage #(
    parameter int WORDSIZE    = 64,
    parameter int REGADDRSIZE = 5,
    parameter int FLAGSIZE    = 4,
    parameter int CTRLSIZE    = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   validin,
    input  logic [CTRLSIZE-1:0]    controlin,
    input  logic [REGADDRSIZE-1:0] rdin,
    input  logic [WORDSIZE-1:0]    readmemin,
    input  logic [WORDSIZE-1:0]    aluresin,
    input  logic [WORDSIZE-1:0]    movresin,
    input  logic [FLAGSIZE-1:0]    flagsin,
    input  logic [REGADDRSIZE-1:0] rn,
    input  logic [REGADDRSIZE-1:0] rm,
    output logic [WORDSIZE-1:0]    rndata,
    output logic [WORDSIZE-1:0]    rmdata,
    output logic [WORDSIZE-1:0]    wbdata,
    output logic                   wbwrite,
    output logic [FLAGSIZE-1:0]    flagsout,
    output logic [WORDSIZE-1:0]    retired
);

    localparam int NREGS = 31;
    localparam logic [REGADDRSIZE-1:0] XZR = REGADDRSIZE'(31);

    logic regwrite;
    logic memtoreg;
    logic movtoreg;
    logic setflags;
    logic live;

    logic [WORDSIZE-1:0] regs [0:NREGS-1];

    assign regwrite = controlin[0];
    assign memtoreg = controlin[1];
    assign movtoreg = controlin[2];
    assign setflags = controlin[3];

    // Gating every side effect with live keeps a bubble's X control bits from leaking into state.
    assign live    = validin & resetn;
    assign wbwrite = live & regwrite & (rdin != XZR);

    always_comb begin
        wbdata = aluresin;
        if (memtoreg) begin
            wbdata = readmemin;
        end else if (movtoreg) begin
            wbdata = movresin;
        end
    end

    always_comb begin
        rndata = '0;
        if (rn != XZR) begin
            if (wbwrite && (rn == rdin)) begin
                rndata = wbdata;
            end else begin
                rndata = regs[rn];
            end
        end
    end

    always_comb begin
        rmdata = '0;
        if (rm != XZR) begin
            if (wbwrite && (rm == rdin)) begin
                rmdata = wbdata;
            end else begin
                rmdata = regs[rm];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flagsout <= '0;
            retired  <= '0;
        end else begin
            if (wbwrite) begin
                regs[rdin] <= wbdata;
            end
            if (validin && setflags) begin
                flagsout <= flagsin;
            end
            if (validin) begin
                retired <= retired + WORDSIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_wbstage.sv
// tb/tb_wbstage.sv - randomized model-checked bench for wbstage
module tb_wbstage;

    logic        clk;
    logic        resetn;
    logic        validin;
    logic [3:0]  controlin;
    logic [4:0]  rdin;
    logic [63:0] readmemin;
    logic [63:0] aluresin;
    logic [63:0] movresin;
    logic [3:0]  flagsin;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] rndata;
    logic [63:0] rmdata;
    logic [63:0] wbdata;
    logic        wbwrite;
    logic [3:0]  flagsout;
    logic [63:0] retired;

    logic        validin8;
    logic [7:0]  rndata8;
    logic [7:0]  rmdata8;
    logic [7:0]  wbdata8;
    logic        wbwrite8;
    logic [3:0]  flagsout8;
    logic [7:0]  retired8;

    int checks;
    int errors;

    logic [63:0] mregs [0:31];
    logic [3:0]  mflags;
    logic [63:0] mret;

    wbstage dut (
        .clk(clk), .resetn(resetn), .validin(validin), .controlin(controlin),
        .rdin(rdin), .readmemin(readmemin), .aluresin(aluresin), .movresin(movresin),
        .flagsin(flagsin), .rn(rn), .rm(rm), .rndata(rndata), .rmdata(rmdata),
        .wbdata(wbdata), .wbwrite(wbwrite), .flagsout(flagsout), .retired(retired)
    );

    wbstage #(.WORDSIZE(8)) dut8 (
        .clk(clk), .resetn(resetn), .validin(validin8), .controlin(4'b0001),
        .rdin(5'd3), .readmemin(8'h00), .aluresin(8'h5a), .movresin(8'h00),
        .flagsin(4'h0), .rn(5'd0), .rm(5'd1), .rndata(rndata8), .rmdata(rmdata8),
        .wbdata(wbdata8), .wbwrite(wbwrite8), .flagsout(flagsout8), .retired(retired8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] exp_wb();
        if (controlin[1]) return readmemin;
        if (controlin[2]) return movresin;
        return aluresin;
    endfunction

    function automatic logic exp_write();
        return resetn && validin && controlin[0] && (rdin != 5'd31);
    endfunction

    function automatic logic [63:0] exp_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (exp_write() && a == rdin) return exp_wb();
        return mregs[a];
    endfunction

    // Architectural effect of the instruction currently presented, applied at the coming edge.
    task automatic model_commit();
        if (!resetn) begin
            for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
            mflags = 4'd0;
            mret   = 64'd0;
        end else if (validin) begin
            if (exp_write()) mregs[rdin] = exp_wb();
            if (controlin[3]) mflags = flagsin;
            mret = mret + 64'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        model_commit();
        tick();
    endtask

    task automatic test_alu_write();
        validin = 1'b1; controlin = 4'b0001; rdin = 5'd5; aluresin = 64'h1234;
        rn = 5'd5; rm = 5'd5;
        #1;
        checks++;
        if (rndata !== 64'h1234) begin errors++; $display("FAIL alu_bypass_rn got %h want %h", rndata, 64'h1234); end
        checks++;
        if (rmdata !== 64'h1234) begin errors++; $display("FAIL alu_bypass_rm got %h want %h", rmdata, 64'h1234); end
        checks++;
        if (wbwrite !== 1'b1) begin errors++; $display("FAIL alu_wbwrite got %b want 1", wbwrite); end
        step();
        validin = 1'b0;
        #1;
        checks++;
        if (rndata !== 64'h1234) begin errors++; $display("FAIL alu_stored got %h want %h", rndata, 64'h1234); end
        checks++;
        if (retired !== 64'd1) begin errors++; $display("FAIL alu_retired got %0d want 1", retired); end
    endtask

    task automatic test_source_select();
        readmemin = 64'hAA; movresin = 64'hBB; aluresin = 64'hCC; validin = 1'b1;
        controlin = 4'b0011; rdin = 5'd1; #1;
        checks++;
        if (wbdata !== 64'hAA) begin errors++; $display("FAIL sel_mem got %h want aa", wbdata); end
        step();
        controlin = 4'b0101; rdin = 5'd2; #1;
        checks++;
        if (wbdata !== 64'hBB) begin errors++; $display("FAIL sel_mov got %h want bb", wbdata); end
        step();
        controlin = 4'b0111; rdin = 5'd3; #1;
        step();
        validin = 1'b0; rn = 5'd1; rm = 5'd2; #1;
        checks++;
        if (rndata !== 64'hAA) begin errors++; $display("FAIL sel_x1 got %h want aa", rndata); end
        checks++;
        if (rmdata !== 64'hBB) begin errors++; $display("FAIL sel_x2 got %h want bb", rmdata); end
        rn = 5'd3; #1;
        checks++;
        if (rndata !== 64'hAA) begin errors++; $display("FAIL sel_x3_priority got %h want aa", rndata); end
    endtask

    task automatic test_xzr_bubble();
        logic [63:0] r4;
        logic [63:0] ret0;
        logic [3:0]  fl0;
        validin = 1'b1; controlin = 4'b0001; rdin = 5'd31; aluresin = rnd64();
        rn = 5'd31; rm = 5'd31; #1;
        checks++;
        if (wbwrite !== 1'b0) begin errors++; $display("FAIL xzr_wbwrite got %b want 0", wbwrite); end
        checks++;
        if (rndata !== 64'd0 || rmdata !== 64'd0) begin
            errors++; $display("FAIL xzr_read got %h/%h want 0", rndata, rmdata);
        end
        ret0 = mret + 64'd1;
        step();
        checks++;
        if (retired !== ret0) begin errors++; $display("FAIL xzr_counted got %0d want %0d", retired, ret0); end
        r4 = mregs[4]; fl0 = mflags; ret0 = mret;
        validin = 1'b0; controlin = 4'b1111; rdin = 5'd4;
        readmemin = 'x; aluresin = 'x; movresin = 'x; flagsin = 4'b1111;
        rn = 5'd4; rm = 5'd4; #1;
        checks++;
        if (wbwrite !== 1'b0) begin errors++; $display("FAIL bubble_wbwrite got %b want 0", wbwrite); end
        checks++;
        if (rndata !== r4) begin errors++; $display("FAIL bubble_read got %h want %h", rndata, r4); end
        step();
        checks++;
        if (rmdata !== r4) begin errors++; $display("FAIL bubble_reg got %h want %h", rmdata, r4); end
        checks++;
        if (flagsout !== fl0) begin errors++; $display("FAIL bubble_flags got %b want %b", flagsout, fl0); end
        checks++;
        if (retired !== ret0) begin errors++; $display("FAIL bubble_count got %0d want %0d", retired, ret0); end
        readmemin = 64'd0; aluresin = 64'd0; movresin = 64'd0;
    endtask

    task automatic test_flags();
        logic [63:0] r9;
        r9 = mregs[9];
        validin = 1'b1; controlin = 4'b1000; flagsin = 4'b0110; rdin = 5'd9;
        aluresin = 64'hDEAD; rn = 5'd9; #1;
        checks++;
        if (wbwrite !== 1'b0) begin errors++; $display("FAIL flags_nowrite got %b want 0", wbwrite); end
        step();
        checks++;
        if (flagsout !== 4'b0110) begin errors++; $display("FAIL flags_set got %b want 0110", flagsout); end
        checks++;
        if (rndata !== r9) begin errors++; $display("FAIL flags_reg got %h want %h", rndata, r9); end
        controlin = 4'b0001; flagsin = 4'b1001; #1;
        step();
        checks++;
        if (flagsout !== 4'b0110) begin errors++; $display("FAIL flags_hold got %b want 0110", flagsout); end
    endtask

    task automatic test_random();
        logic [63:0] e;
        for (int n = 0; n < 400; n++) begin
            validin   = ($urandom_range(0, 3) != 0);
            controlin = 4'($urandom);
            rdin      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            readmemin = rnd64(); aluresin = rnd64(); movresin = rnd64();
            flagsin   = 4'($urandom);
            rn = ($urandom_range(0, 2) == 0) ? rdin : 5'($urandom);
            rm = ($urandom_range(0, 2) == 0) ? rdin : 5'($urandom);
            #1;
            checks++;
            if (wbwrite !== exp_write()) begin errors++; $display("FAIL rnd_wbwrite n=%0d got %b want %b", n, wbwrite, exp_write()); end
            if (validin) begin
                e = exp_wb();
                checks++;
                if (wbdata !== e) begin errors++; $display("FAIL rnd_wbdata n=%0d got %h want %h", n, wbdata, e); end
            end
            e = exp_read(rn);
            checks++;
            if (rndata !== e) begin errors++; $display("FAIL rnd_rn n=%0d rn=%0d got %h want %h", n, rn, rndata, e); end
            e = exp_read(rm);
            checks++;
            if (rmdata !== e) begin errors++; $display("FAIL rnd_rm n=%0d rm=%0d got %h want %h", n, rm, rmdata, e); end
            step();
            checks++;
            if (flagsout !== mflags) begin errors++; $display("FAIL rnd_flags n=%0d got %b want %b", n, flagsout, mflags); end
            checks++;
            if (retired !== mret) begin errors++; $display("FAIL rnd_retired n=%0d got %0d want %0d", n, retired, mret); end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; validin = 1'b1; controlin = 4'b1001; rdin = 5'd6;
        aluresin = rnd64(); flagsin = 4'b1111;
        step();
        step();
        resetn = 1'b1; validin = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rn = 5'(a); rm = 5'(31 - a); #1;
            checks++;
            if (rndata !== 64'd0 || rmdata !== 64'd0) begin
                errors++; $display("FAIL reset_read a=%0d got %h/%h want 0", a, rndata, rmdata);
            end
        end
        checks++;
        if (flagsout !== 4'd0) begin errors++; $display("FAIL reset_flags got %b want 0", flagsout); end
        checks++;
        if (retired !== 64'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    endtask

    task automatic test_midrun_reset();
        validin = 1'b1; controlin = 4'b0001; rdin = 5'd8; aluresin = 64'h77;
        step();
        resetn = 1'b0; rdin = 5'd7; aluresin = 64'h5555; rn = 5'd7; #1;
        checks++;
        if (wbwrite !== 1'b0) begin errors++; $display("FAIL midreset_wbwrite got %b want 0", wbwrite); end
        step();
        resetn = 1'b1; validin = 1'b0; rm = 5'd8; #1;
        checks++;
        if (rndata !== 64'd0) begin errors++; $display("FAIL midreset_x7 got %h want 0", rndata); end
        checks++;
        if (rmdata !== 64'd0) begin errors++; $display("FAIL midreset_x8 got %h want 0", rmdata); end
        checks++;
        if (retired !== 64'd0) begin errors++; $display("FAIL midreset_retired got %0d want 0", retired); end
    endtask

    task automatic test_wrap();
        validin8 = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        checks++;
        if (retired8 !== 8'd255) begin errors++; $display("FAIL wrap_top got %0d want 255", retired8); end
        tick();
        checks++;
        if (retired8 !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", retired8); end
        validin8 = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        resetn = 1'b0; validin = 1'b0; validin8 = 1'b0; controlin = 4'd0; rdin = 5'd0;
        readmemin = 64'd0; aluresin = 64'd0; movresin = 64'd0; flagsin = 4'd0;
        rn = 5'd0; rm = 5'd0;
        #2;
        step();
        step();
        resetn = 1'b1;
        test_alu_write();
        test_source_select();
        test_xzr_bubble();
        test_flags();
        test_random();
        test_reset();
        test_midrun_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbstage.md
Name: wbstage

Overview:
- Write-back stage of the pipelined LEGv8 core, on the consuming side of the MEM/WB pipeline register.
- Selects the write-back value from the memory, ALU or MOV result and commits it to the architectural register file (X0–X30, XZR).
- Commits NZCV flags for flag-setting instructions and counts retired instructions.
- Serves the ID stage through two read ports with write-through bypass, so an instruction in WB is visible to a same-cycle read in ID.

Parameters:
- WORDSIZE, 64, datapath and register width
- REGADDRSIZE, 5, register address width
- FLAGSIZE, 4, NZCV flag width (bit3 N, bit2 Z, bit1 C, bit0 V)
- CTRLSIZE, 4, write-back control width (bit0 regwrite, bit1 memtoreg, bit2 movtoreg, bit3 setflags)

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  synchronous, active-low reset
- validin  in  1  instruction present in WB (0 = bubble)
- controlin  in  CTRLSIZE  write-back control from MEM/WB
- rdin  in  REGADDRSIZE  destination register
- readmemin  in  WORDSIZE  load data
- aluresin  in  WORDSIZE  ALU result
- movresin  in  WORDSIZE  MOVZ/MOVK result
- flagsin  in  FLAGSIZE  flags produced by the instruction
- rn  in  REGADDRSIZE  read port A address
- rm  in  REGADDRSIZE  read port B address
- rndata  out  WORDSIZE  read port A data
- rmdata  out  WORDSIZE  read port B data
- wbdata  out  WORDSIZE  selected write-back value (forwarding source)
- wbwrite  out  1  effective register write this cycle
- flagsout  out  FLAGSIZE  architectural NZCV
- retired  out  WORDSIZE  retired-instruction counter

Behaviour:
- Definitions:
  - regwrite = controlin[0]
  - memtoreg = controlin[1]
  - movtoreg = controlin[2]
  - setflags = controlin[3]
  - live = validin & resetn
- wbdata is combinational. Priority: memtoreg → readmemin, else movtoreg → movresin, else aluresin. If both memtoreg and movtoreg are set, memtoreg wins.
- wbwrite = live & regwrite & (rdin != 31).
- Register file:
  - 31 × WORDSIZE registers, indices 0–30.
  - On posedge with wbwrite, reg[rdin] <= wbdata.
  - Writes to 31 are discarded.
  - When validin=0, controlin is ignored entirely (no write, no flags, no count).
- Read ports are combinational:
  - Address 31 returns 0 (XZR), with no bypass.
  - Otherwise, if wbwrite & addr == rdin, return wbdata (bypass).
  - Otherwise return reg[addr].
  - Both ports may hit the bypass in the same cycle.
- Flags: on posedge with live & setflags, flagsout <= flagsin. A setflags instruction with regwrite=0 (CMP/SUBS to XZR) still updates flags. Flags are not bypassed; flagsout shows the value after the edge.
- Retired counter: on posedge with live, retired <= retired + 1, wrapping modulo 2^WORDSIZE. Counts every valid instruction, including stores, branches and writes to XZR.
- Reset (resetn=0 at posedge):
  - All 31 registers, flagsout and retired are set to 0.
  - Any write, flag update or count presented in that cycle is suppressed.
  - Read ports are combinational and reflect the new zeroed state from the next cycle onward.
- Latency:
  - Register, flag and counter updates take effect 1 edge after presentation.
  - The read-port bypass has 0-cycle latency.
- Simultaneous events: a write and both reads to the same register in one cycle return the new value on both ports.
- X-safety: when validin=0, outputs depend on no X values from controlin or data inputs, except wbdata, which is don't-care.

Test Plan:
- Reset: hold resetn=0 for 2 cycles after random writes → rndata=rmdata=0 for all rn/rm in 0–31; flagsout=0; retired=0.
- ALU write then read: validin=1, control=0001, rdin=5, aluresin=0x1234 → rndata(rn=5)=0x1234 in the same cycle via bypass and after the edge from storage; retired=1.
- Source select: control=0011 readmemin=0xAA; then control=0101 movresin=0xBB; then control=0111 → X1=0xAA, X2=0xBB, X3=0xAA (memtoreg priority).
- XZR and bubble:
  - rdin=31 with regwrite → wbwrite=0; rndata(31)=0.
  - validin=0 with control=1111 → no register, flag or count change.
- Flags: control=1000, flagsin=0b0110 → flagsout=0110 after the edge, no register write; the next control=0001 leaves flagsout=0110.
- Mid-run reset and wrap:
  - Force retired to 2^64−1 (or run a reduced WORDSIZE=8 instance for 256 valid cycles) → wraps to 0.
  - Assert resetn=0 in the same cycle as a write to X7 → X7 stays 0 and retired stays 0.
